// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - address map helpers and parameter legality check for mmio_port_bank
package mmio_pkg;

  localparam int OUT_BASE = 0;

  function automatic int IN_BASE(input int num_out);
    return OUT_BASE + num_out;
  endfunction

  function automatic int STATUS_ADDR(input int num_out, input int num_in);
    return IN_BASE(num_out) + num_in;
  endfunction

  function automatic int MASK_ADDR(input int num_out, input int num_in);
    return STATUS_ADDR(num_out, num_in) + 1;
  endfunction

  // STATUS and MASK must fit in the decoded range and hold one bit per input.
  function automatic bit params_legal(input int addr_w, input int data_w, input int num_out,
                                      input int num_in, input int sync_stages);
    return (num_out >= 1) && (num_in >= 1) && (sync_stages >= 2) && (data_w >= num_in) &&
           ((num_out + num_in + 2) <= (1 << addr_w));
  endfunction

endpackage

// File: rtl/sync_bus.sv
// rtl/sync_bus.sv - multi-flop synchroniser for an asynchronous input bus
module sync_bus #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < STAGES; s++) r_stage[s] <= '0;
    end else begin
      r_stage[0] <= i_data;
      for (int s = 1; s < STAGES; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign o_data = r_stage[STAGES-1];

endmodule

// File: rtl/mmio_port_bank.sv
// rtl/mmio_port_bank.sv - MMIO output registers, synchronised inputs, change flags and IRQ
module mmio_port_bank
  import mmio_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int NUM_OUT     = 4,
  parameter int NUM_IN      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [ADDR_W-1:0]         IOAddr,
  input  logic                      IOWriteEn,
  input  logic                      IOReadEn,
  input  logic [DATA_W-1:0]         IOWriteData,
  output logic [DATA_W-1:0]         IOReadData,
  input  logic [NUM_IN*DATA_W-1:0]  InPort,
  output logic [NUM_OUT*DATA_W-1:0] OutPort,
  output logic                      IRQ
);

  localparam int              IN_B     = IN_BASE(NUM_OUT);
  localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(STATUS_ADDR(NUM_OUT, NUM_IN));
  localparam logic [ADDR_W-1:0] MASK_A   = ADDR_W'(MASK_ADDR(NUM_OUT, NUM_IN));

  if (!params_legal(ADDR_W, DATA_W, NUM_OUT, NUM_IN, SYNC_STAGES)) begin : g_bad_params
    $error("mmio_port_bank: illegal parameter combination");
  end

  logic [DATA_W-1:0] r_out  [NUM_OUT];
  logic [DATA_W-1:0] r_prev [NUM_IN];
  logic [DATA_W-1:0] w_sync [NUM_IN];
  logic [NUM_IN-1:0] r_chg;
  logic [NUM_IN-1:0] r_mask;
  logic [NUM_IN-1:0] w_chg_set;
  logic              w_status_rd;
  logic [DATA_W-1:0] w_rdata;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    sync_bus #(
      .WIDTH  (DATA_W),
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .i_clk   (CLK),
      .i_rst_n (RESET),
      .i_data  (InPort[i*DATA_W +: DATA_W]),
      .o_data  (w_sync[i])
    );
    assign w_chg_set[i] = (w_sync[i] != r_prev[i]);
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
    assign OutPort[i*DATA_W +: DATA_W] = r_out[i];
  end

  assign w_status_rd = IOReadEn && (IOAddr == STATUS_A);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_OUT; i++) r_out[i] <= '0;
      r_mask <= '0;
    end else if (IOWriteEn) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (IOAddr == ADDR_W'(OUT_BASE + i)) r_out[i] <= IOWriteData;
      end
      if (IOAddr == MASK_A) r_mask <= IOWriteData[NUM_IN-1:0];
    end
  end

  // A flag being set on the clearing edge survives; all other bits clear.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_IN; i++) r_prev[i] <= '0;
      r_chg <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) r_prev[i] <= w_sync[i];
      r_chg <= w_chg_set | (r_chg & {NUM_IN{~w_status_rd}});
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (IOAddr == ADDR_W'(OUT_BASE + i)) w_rdata = r_out[i];
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (IOAddr == ADDR_W'(IN_B + i)) w_rdata = w_sync[i];
    end
    if (IOAddr == STATUS_A) w_rdata = DATA_W'(r_chg);
    if (IOAddr == MASK_A)   w_rdata = DATA_W'(r_mask);
  end

  assign IOReadData = w_rdata;
  assign IRQ        = |(r_chg & r_mask);

endmodule
